// File: rtl/bomb_pool.sv
// Pooled bomb slots for all players: placement with cell-occupancy checks,
// frame-counted fuse and blast timers, and one-hop-per-cycle chain reactions.
module bomb_pool #(
   parameter int NUM_PLAYERS      = 2,
   parameter int BOMBS_PER_PLAYER = 4,
   parameter int FUSE_FRAMES      = 120,
   parameter int BLAST_FRAMES     = 30,
   parameter int RANGE            = 2
) (
   input  logic                                                Clk,
   input  logic                                                Reset,
   input  logic                                                frame_clk,
   input  logic [NUM_PLAYERS-1:0]                              place_req,
   input  logic [4*NUM_PLAYERS-1:0]                            place_X,
   input  logic [4*NUM_PLAYERS-1:0]                            place_Y,
   output logic [NUM_PLAYERS-1:0]                              place_ack,
   output logic [NUM_PLAYERS-1:0]                              place_nack,
   output logic [2*NUM_PLAYERS*BOMBS_PER_PLAYER-1:0]           slot_state,
   output logic [4*NUM_PLAYERS*BOMBS_PER_PLAYER-1:0]           slot_X,
   output logic [4*NUM_PLAYERS*BOMBS_PER_PLAYER-1:0]           slot_Y,
   output logic [NUM_PLAYERS*BOMBS_PER_PLAYER-1:0]             explode_pulse,
   output logic [NUM_PLAYERS*$clog2(BOMBS_PER_PLAYER+1)-1:0]   bomb_count
);
   localparam int P    = NUM_PLAYERS;
   localparam int B    = BOMBS_PER_PLAYER;
   localparam int S    = P * B;
   localparam int MAXF = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
   localparam int CW   = $clog2(MAXF + 1);
   localparam int BCW  = $clog2(B + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FUSE  = 2'd1;
   localparam logic [1:0] ST_BLAST = 2'd2;

   localparam logic signed [4:0] RNG = 5'(RANGE);

   logic              sync1_q, sync2_q, sync3_q, tick_q, tick_d;
   logic [P-1:0]      prev_req_q;
   logic [P-1:0]      ack_q, ack_d, nack_q, nack_d;
   logic [1:0]        state_q [S];
   logic [1:0]        state_d [S];
   logic [CW-1:0]     cnt_q [S];
   logic [CW-1:0]     cnt_d [S];
   logic [3:0]        x_q [S];
   logic [3:0]        x_d [S];
   logic [3:0]        y_q [S];
   logic [3:0]        y_d [S];
   logic [S-1:0]      explode_q, explode_d;
   logic [BCW-1:0]    count_q [P];
   logic [BCW-1:0]    count_d [P];
   logic [S-1:0]      alloc, chain;

   function automatic logic in_range(input logic [3:0] a, input logic [3:0] b);
      logic signed [4:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d[4]) d = -d;
      return d <= RNG;
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         tick_q     <= 1'b0;
         prev_req_q <= '1;
         ack_q      <= '0;
         nack_q     <= '0;
         explode_q  <= '0;
         for (int s = 0; s < S; s++) begin
            state_q[s] <= ST_IDLE;
            cnt_q[s]   <= '0;
            x_q[s]     <= '0;
            y_q[s]     <= '0;
         end
         for (int p = 0; p < P; p++) count_q[p] <= '0;
      end else begin
         sync1_q    <= frame_clk;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         tick_q     <= tick_d;
         prev_req_q <= place_req;
         ack_q      <= ack_d;
         nack_q     <= nack_d;
         explode_q  <= explode_d;
         for (int s = 0; s < S; s++) begin
            state_q[s] <= state_d[s];
            cnt_q[s]   <= cnt_d[s];
            x_q[s]     <= x_d[s];
            y_q[s]     <= y_d[s];
         end
         for (int p = 0; p < P; p++) count_q[p] <= count_d[p];
      end
   end

   // A fusing slot detonates when any other blasting slot shares its row or column within reach.
   always_comb begin
      chain = '0;
      for (int s = 0; s < S; s++)
         for (int o = 0; o < S; o++)
            if (o != s && state_q[o] == ST_BLAST &&
                ((x_q[o] == x_q[s] && in_range(y_q[o], y_q[s])) ||
                 (y_q[o] == y_q[s] && in_range(x_q[o], x_q[s]))))
               chain[s] = 1'b1;
   end

   // Lower player index is resolved first, so it wins a same-cell collision.
   always_comb begin
      logic [3:0] px, py;
      logic       occupied, found;
      int         pick;
      ack_d    = '0;
      nack_d   = '0;
      alloc    = '0;
      px       = '0;
      py       = '0;
      occupied = 1'b0;
      found    = 1'b0;
      pick     = 0;
      for (int p = 0; p < P; p++) begin
         if (place_req[p] && !prev_req_q[p]) begin
            px       = place_X[4*p +: 4];
            py       = place_Y[4*p +: 4];
            occupied = 1'b0;
            for (int s = 0; s < S; s++)
               if (state_q[s] != ST_IDLE && x_q[s] == px && y_q[s] == py) occupied = 1'b1;
            for (int q = 0; q < p; q++)
               if (ack_d[q] && place_X[4*q +: 4] == px && place_Y[4*q +: 4] == py) occupied = 1'b1;
            found = 1'b0;
            pick  = 0;
            for (int b = B - 1; b >= 0; b--)
               if (state_q[p*B + b] == ST_IDLE) begin
                  found = 1'b1;
                  pick  = b;
               end
            if (!found || occupied) nack_d[p] = 1'b1;
            else begin
               ack_d[p]          = 1'b1;
               alloc[p*B + pick] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      tick_d = sync2_q & ~sync3_q;
      for (int s = 0; s < S; s++) begin
         state_d[s] = state_q[s];
         cnt_d[s]   = cnt_q[s];
         x_d[s]     = x_q[s];
         y_d[s]     = y_q[s];
         case (state_q[s])
            ST_IDLE: begin
               if (alloc[s]) begin
                  state_d[s] = ST_FUSE;
                  cnt_d[s]   = CW'(FUSE_FRAMES);
                  x_d[s]     = place_X[4*(s/B) +: 4];
                  y_d[s]     = place_Y[4*(s/B) +: 4];
               end
            end
            ST_FUSE: begin
               if (chain[s] || (tick_q && cnt_q[s] == CW'(1))) begin
                  state_d[s] = ST_BLAST;
                  cnt_d[s]   = CW'(BLAST_FRAMES);
               end else if (tick_q) begin
                  cnt_d[s] = cnt_q[s] - CW'(1);
               end
            end
            ST_BLAST: begin
               if (tick_q) begin
                  cnt_d[s] = cnt_q[s] - CW'(1);
                  if (cnt_q[s] == CW'(1)) state_d[s] = ST_IDLE;
               end
            end
            default: begin
               state_d[s] = ST_IDLE;
               cnt_d[s]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      for (int s = 0; s < S; s++)
         explode_d[s] = (state_q[s] == ST_FUSE) && (state_d[s] == ST_BLAST);
      for (int p = 0; p < P; p++) begin
         count_d[p] = '0;
         for (int b = 0; b < B; b++)
            if (state_q[p*B + b] != ST_IDLE) count_d[p] = count_d[p] + BCW'(1);
      end
      for (int s = 0; s < S; s++) begin
         slot_state[2*s +: 2] = state_q[s];
         slot_X[4*s +: 4]     = x_q[s];
         slot_Y[4*s +: 4]     = y_q[s];
      end
      for (int p = 0; p < P; p++) bomb_count[BCW*p +: BCW] = count_q[p];
   end

   assign place_ack     = ack_q;
   assign place_nack    = nack_q;
   assign explode_pulse = explode_q;

endmodule

// File: tb/tb_bomb_pool.sv
// Scoreboarded bench for bomb_pool: a frame-level reference model queues
// expected ack/nack/explode events; a negedge monitor pops and compares them.
module tb_bomb_pool;
   localparam int P = 2, B = 4, S = 8, FUSE = 3, BLAST = 2, RNG = 2, BCW = 3;

   logic             Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
   logic [P-1:0]     place_req = '0;
   logic [4*P-1:0]   place_X = '0, place_Y = '0;
   logic [P-1:0]     place_ack, place_nack;
   logic [2*S-1:0]   slot_state;
   logic [4*S-1:0]   slot_X, slot_Y;
   logic [S-1:0]     explode_pulse;
   logic [P*BCW-1:0] bomb_count;

   bomb_pool #(.NUM_PLAYERS(P), .BOMBS_PER_PLAYER(B), .FUSE_FRAMES(FUSE),
               .BLAST_FRAMES(BLAST), .RANGE(RNG)) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .place_req(place_req), .place_X(place_X), .place_Y(place_Y),
      .place_ack(place_ack), .place_nack(place_nack),
      .slot_state(slot_state), .slot_X(slot_X), .slot_Y(slot_Y),
      .explode_pulse(explode_pulse), .bomb_count(bomb_count));

   always #5 Clk = ~Clk;

   int checks = 0, errors = 0, cyc = 0;

   typedef struct { int cyc; int kind; int idx; } evt_t;   // kind 0 ack, 1 nack, 2 explode
   evt_t sbq[$];

   // Reference: each slot is {phase 0/1/2, frames left, cell}
   int m_st[S], m_left[S], m_x[S], m_y[S];
   int st0[S], x0[S], y0[S];
   int m_prev[P], m_bc[P];
   bit fh[4];
   bit tk, chained, busy;
   bit ev_ack[P], ev_nack[P], ev_exp[S];
   int cx, cy, free_b, dx, dy;

   initial begin
      for (int s = 0; s < S; s++) begin m_st[s] = 0; m_left[s] = 0; m_x[s] = 0; m_y[s] = 0; end
      for (int p = 0; p < P; p++) begin m_prev[p] = 1; m_bc[p] = 0; end
      for (int i = 0; i < 4; i++) fh[i] = 1'b0;
   end

   always @(posedge Clk) begin
      cyc++;
      if (Reset) begin
         for (int s = 0; s < S; s++) begin m_st[s] = 0; m_left[s] = 0; m_x[s] = 0; m_y[s] = 0; end
         for (int p = 0; p < P; p++) begin m_prev[p] = 1; m_bc[p] = 0; end
         for (int i = 0; i < 4; i++) fh[i] = 1'b0;
      end else begin
         // a frame edge sampled three clocks ago acts on the slots now
         tk = fh[2] && !fh[3];
         st0 = m_st; x0 = m_x; y0 = m_y;
         for (int p = 0; p < P; p++) begin
            m_bc[p] = 0;
            for (int b = 0; b < B; b++) if (st0[p*B+b] != 0) m_bc[p]++;
            ev_ack[p] = 0; ev_nack[p] = 0;
         end
         for (int s = 0; s < S; s++) begin
            ev_exp[s] = 0;
            if (st0[s] == 1) begin
               chained = 0;
               for (int o = 0; o < S; o++) begin
                  dx = x0[o] - x0[s]; dy = y0[o] - y0[s];
                  if (dx < 0) dx = -dx;
                  if (dy < 0) dy = -dy;
                  if (o != s && st0[o] == 2 && ((dx == 0 && dy <= RNG) || (dy == 0 && dx <= RNG)))
                     chained = 1;
               end
               if (chained || (tk && m_left[s] == 1)) begin
                  m_st[s] = 2; m_left[s] = BLAST; ev_exp[s] = 1;
               end else if (tk) m_left[s]--;
            end else if (st0[s] == 2 && tk) begin
               m_left[s]--;
               if (m_left[s] == 0) m_st[s] = 0;
            end
         end
         for (int p = 0; p < P; p++) begin
            if (place_req[p] && m_prev[p] == 0) begin
               cx = int'(place_X[4*p +: 4]); cy = int'(place_Y[4*p +: 4]);
               busy = 0;
               for (int s = 0; s < S; s++) if (st0[s] != 0 && x0[s] == cx && y0[s] == cy) busy = 1;
               for (int q = 0; q < p; q++)
                  if (ev_ack[q] && int'(place_X[4*q +: 4]) == cx && int'(place_Y[4*q +: 4]) == cy) busy = 1;
               free_b = -1;
               for (int b = B - 1; b >= 0; b--) if (st0[p*B+b] == 0) free_b = b;
               if (free_b < 0 || busy) ev_nack[p] = 1;
               else begin
                  ev_ack[p] = 1;
                  m_st[p*B+free_b] = 1; m_left[p*B+free_b] = FUSE;
                  m_x[p*B+free_b] = cx; m_y[p*B+free_b] = cy;
               end
            end
            m_prev[p] = place_req[p] ? 1 : 0;
         end
         for (int i = 3; i > 0; i--) fh[i] = fh[i-1];
         fh[0] = frame_clk;
         for (int p = 0; p < P; p++) if (ev_ack[p])  sbq.push_back('{cyc, 0, p});
         for (int p = 0; p < P; p++) if (ev_nack[p]) sbq.push_back('{cyc, 1, p});
         for (int s = 0; s < S; s++) if (ev_exp[s])  sbq.push_back('{cyc, 2, s});
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic take_evt(input int kind, input int idx);
      evt_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL event: got kind %0d idx %0d at cycle %0d, expected none", kind, idx, cyc);
      end else begin
         e = sbq.pop_front();
         if (e.cyc != cyc || e.kind != kind || e.idx != idx) begin
            errors++;
            $display("FAIL event: got kind %0d idx %0d cycle %0d, expected kind %0d idx %0d cycle %0d",
                     kind, idx, cyc, e.kind, e.idx, e.cyc);
         end
      end
   endtask

   logic [2*S-1:0]   e_st;
   logic [4*S-1:0]   e_x, e_y;
   logic [P*BCW-1:0] e_bc;
   int               stale;

   always @(negedge Clk) begin
      for (int p = 0; p < P; p++) if (place_ack[p])  take_evt(0, p);
      for (int p = 0; p < P; p++) if (place_nack[p]) take_evt(1, p);
      for (int s = 0; s < S; s++) if (explode_pulse[s]) take_evt(2, s);
      stale = 0;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         stale++;
         $display("FAIL missing_event: got nothing, expected kind %0d idx %0d at cycle %0d",
                  sbq[0].kind, sbq[0].idx, sbq[0].cyc);
         void'(sbq.pop_front());
      end
      checks++;
      if (stale != 0) errors++;
      for (int s = 0; s < S; s++) begin
         e_st[2*s +: 2] = 2'(m_st[s]);
         e_x[4*s +: 4]  = 4'(m_x[s]);
         e_y[4*s +: 4]  = 4'(m_y[s]);
      end
      for (int p = 0; p < P; p++) e_bc[BCW*p +: BCW] = BCW'(m_bc[p]);
      chk("model_state", {slot_state, slot_X, slot_Y}, {e_st, e_x, e_y});
      chk("model_count", 64'(bomb_count), 64'(e_bc));
   end

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1; step(2); Reset = 1'b0; step(1);
   endtask

   task automatic hit(input int p, input int x, input int y);
      place_X[4*p +: 4] = 4'(x); place_Y[4*p +: 4] = 4'(y); place_req[p] = 1'b1;
      step(1);
   endtask

   task automatic rel(input int p);
      place_req[p] = 1'b0; step(1);
   endtask

   task automatic frame(input int n);
      repeat (n) begin
         frame_clk = 1'b1; step(2); frame_clk = 1'b0; step(2);
      end
   endtask

   int fcnt;

   initial begin
      step(3);
      Reset = 1'b0;
      step(1);
      chk("reset_state", 64'(slot_state), 64'h0);
      chk("reset_count", 64'(bomb_count), 64'h0);

      // single bomb lifecycle
      hit(0, 5, 5);
      chk("t1_ack", 64'(place_ack), 64'h1);
      chk("t1_fuse", 64'(slot_state[1:0]), 64'h1);
      chk("t1_xy", {slot_X[3:0], slot_Y[3:0]}, 64'h55);
      rel(0);
      chk("t1_count1", 64'(bomb_count[2:0]), 64'h1);
      frame(2);
      chk("t1_still_fuse", 64'(slot_state[1:0]), 64'h1);
      frame(1);
      chk("t1_blast", 64'(slot_state[1:0]), 64'h2);
      frame(2);
      chk("t1_idle", 64'(slot_state[1:0]), 64'h0);
      step(1);
      chk("t1_count0", 64'(bomb_count[2:0]), 64'h0);

      // exhaust player 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         hit(0, i, 7);
         chk("t2_ack", 64'(place_ack), 64'h1);
         rel(0);
      end
      hit(0, 9, 9);
      chk("t2_nack_full", 64'(place_nack), 64'h1);
      rel(0);
      chk("t2_count4", 64'(bomb_count[2:0]), 64'h4);
      chk("t2_states", 64'(slot_state[7:0]), 64'h55);

      // same-cell collision
      do_reset();
      place_X = {4'd3, 4'd3}; place_Y = {4'd3, 4'd3}; place_req = 2'b11;
      step(1);
      chk("t3_ack", 64'(place_ack), 64'h1);
      chk("t3_nack", 64'(place_nack), 64'h2);
      chk("t3_slot4_idle", 64'(slot_state[9:8]), 64'h0);
      place_req = 2'b00; step(1);

      // chain reaction within range
      do_reset();
      hit(0, 4, 4); rel(0);
      frame(1);
      hit(1, 4, 6); rel(1);
      frame(2);
      chk("t4_src_blast", 64'(slot_state[1:0]), 64'h2);
      chk("t4_tgt_not_yet", 64'(slot_state[9:8]), 64'h1);
      step(1);
      chk("t4_tgt_chained", 64'(slot_state[9:8]), 64'h2);
      frame(3);

      // out of range: no chain
      do_reset();
      hit(0, 4, 4); rel(0);
      frame(1);
      hit(1, 4, 7); rel(1);
      frame(2);
      step(1);
      chk("t4b_src_blast", 64'(slot_state[1:0]), 64'h2);
      chk("t4b_no_chain", 64'(slot_state[9:8]), 64'h1);
      frame(4);

      // blocked by blast, then slot reuse
      do_reset();
      hit(0, 2, 2); rel(0);
      frame(3);
      chk("t5_blast", 64'(slot_state[1:0]), 64'h2);
      hit(1, 2, 2);
      chk("t5_nack_blast", 64'(place_nack), 64'h2);
      rel(1);
      frame(2);
      chk("t5_idle", 64'(slot_state[1:0]), 64'h0);
      hit(0, 2, 2);
      chk("t5_reuse_ack", 64'(place_ack), 64'h1);
      chk("t5_reuse_slot0", 64'(slot_state[3:0]), 64'h1);
      rel(0);

      // reset with request held
      do_reset();
      hit(0, 1, 1); rel(0);
      hit(0, 2, 1); rel(0);
      hit(0, 3, 1);
      chk("t6_third_ack", 64'(place_ack), 64'h1);
      Reset = 1'b1; step(1);
      chk("t6_cleared", 64'(slot_state), 64'h0);
      chk("t6_no_pulse", {place_ack, place_nack, explode_pulse}, 64'h0);
      Reset = 1'b0; step(4);
      chk("t6_held_nothing", 64'(slot_state), 64'h0);
      rel(0);
      hit(0, 3, 1);
      chk("t6_replace_ack", 64'(place_ack), 64'h1);
      rel(0);

      // randomized traffic on a small board to provoke collisions and chains
      fcnt = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < P; p++)
            if ($urandom_range(3) == 0) begin
               if (!place_req[p]) begin
                  place_X[4*p +: 4] = 4'($urandom_range(5));
                  place_Y[4*p +: 4] = 4'($urandom_range(5));
               end
               place_req[p] = ~place_req[p];
            end
         if (fcnt == 0) begin
            frame_clk = ~frame_clk;
            fcnt = int'($urandom_range(6, 1));
         end else fcnt--;
         Reset = ($urandom_range(599) == 0);
         step(1);
      end
      Reset = 1'b0; place_req = '0; frame_clk = 1'b0;
      frame(8);
      step(4);
      chk("queue_drained", 64'(sbq.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bomb_pool.md
# bomb_pool

Bomb bank for the bomberman core. It replaces the fixed two-players-by-four-bombs array of separate bomb state machines with one parametrised pool of NUM_PLAYERS × BOMBS_PER_PLAYER slots, and it counts fuse and blast time in VGA frames. It allocates a slot when a player places a bomb, rejects placement on an occupied cell, and triggers chain reactions between bombs within blast range. It sits between the player movement logic (bomberman) and the map and game-state logic, which consume per-slot state and coordinates.

## Interface
- NUM_PLAYERS, 2, number of players P
- BOMBS_PER_PLAYER, 4, slots per player B; slot index s = p*B + b, S = P*B
- FUSE_FRAMES, 120, frames from placement to explosion (≥1)
- BLAST_FRAMES, 30, frames a blast stays active (≥1)
- RANGE, 2, blast reach in tiles along row and column (0..15)

- Clk  in  1  system clock (CLOCK_50)
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  VGA vsync, asynchronous to Clk; a frame is one rising edge
- place_req  in  P  per-player place request, level signal (key held)
- place_X, place_Y  in  4*P  tile coordinates of each player, packed with player p at [4p+3:4p]
- place_ack  out  P  one-cycle pulse when a bomb is placed
- place_nack  out  P  one-cycle pulse when a request is rejected
- slot_state  out  2*S  per slot: 0 IDLE, 1 FUSE, 2 BLAST
- slot_X, slot_Y  out  4*S  tile of each slot; holds its last value when IDLE
- explode_pulse  out  S  one-cycle pulse on the FUSE→BLAST transition
- bomb_count  out  P*$clog2(B+1)  number of non-IDLE slots per player

## Operation
- Frame tick: frame_clk passes through a 2-flop synchronizer and a rising-edge detector to form `tick`, a one-cycle pulse.
- Request edge: per player, prev_req is registered. A placement attempt occurs when place_req=1 and prev_req=0.
- Attempt handling:
  - Reject with nack if the player has no IDLE slot.
  - Reject with nack if any non-IDLE slot (FUSE or BLAST, either player) is at (place_X, place_Y).
  - Otherwise take the player's lowest-index IDLE slot: state becomes FUSE, X/Y are latched, the counter loads FUSE_FRAMES, and ack is pulsed.
- Simultaneous attempts on the same cell: the lower player index wins and the other player gets nack. Attempts on different cells are handled independently.
- Per-slot FSM:
  - IDLE→FUSE on placement.
  - FUSE: the counter decrements on each tick. On tick with counter==1, go to BLAST, load BLAST_FRAMES, and pulse explode.
  - FUSE→BLAST also happens immediately on chain: any other slot in BLAST with the same X and |ΔY|≤RANGE, or the same Y and |ΔX|≤RANGE. Chain takes priority over tick.
  - BLAST: decrement on tick. On tick with counter==1, go to IDLE.
- Chain propagates one hop per Clk cycle. Walls are not considered; the map logic masks blast visuals.
- Counter width is $clog2(max(FUSE_FRAMES, BLAST_FRAMES)+1). Differences are computed in 5-bit signed arithmetic.
- bomb_count is the registered popcount of non-IDLE slots per player.

## Timing
- Reset values: all slots IDLE, slot_X/Y 0, counters 0, all pulses 0, bomb_count 0, synchronizer flops 0.
- prev_req resets to 1, so a request held across reset places nothing until it is released and pressed again.
- frame_clk rise → tick is asserted 3 Clk cycles later.
- Request edge at cycle n → at n+1, slot_state=FUSE and ack/nack are asserted; bomb_count updates at n+2.
- A placed bomb explodes on exactly the FUSE_FRAMES-th tick after placement.
- Explosion timing: explode_pulse and slot_state=BLAST are asserted in the cycle after that tick.
- The bomb returns to IDLE BLAST_FRAMES ticks later.
- Chain latency is 1 Clk cycle per hop.
- A slot that returns to IDLE in cycle n is allocatable from cycle n+1, not in the same cycle.
- A Reset asserted mid-operation clears everything on the next edge with no pulses emitted.
- A held place_req never re-places.

## Test plan
- P=2, B=4, FUSE=3, BLAST=2; player 0 at (5,5) presses once → ack0 at n+1, slot0 FUSE (5,5); explode_pulse[0] after the 3rd tick; IDLE after 2 more ticks; bomb_count0 goes 1 then 0.
- Player 0 presses at 5 distinct cells, no ticks → four acks, slots 0–3 FUSE, 5th press gives nack0, bomb_count0=4.
- Both players press in the same cycle at (3,3) → ack0, nack1, slot0 FUSE, slot4 IDLE.
- RANGE=2; bombs at (4,4) by P0 and (4,6) by P1 placed 1 tick apart → slot4 enters BLAST one Clk after slot0 explodes, not on its own fuse. A bomb at (4,7) does not chain.
- Press during a BLAST at the same cell → nack. Press after that slot returns to IDLE → ack and the same slot is reused.
- Reset asserted while 3 bombs are in FUSE and place_req is held high → all IDLE, no pulses, no placement until place_req falls and rises again.
